// File: rtl/mem_access.sv
// mem_access: MEM stage of the pipeline. Decodes loads/stores, drives the data
// bus, waits for the bus ack (or times out), and registers the writeback entry.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no access outstanding; a valid aligned load/store requests now
// S_WAIT | request issued and not yet acked; counter tracks wait cycles
module mem_access #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_mem,
  input  logic [XLEN-1:0] alu_mem,
  input  logic [XLEN-1:0] rs2_mem,
  input  logic [XLEN-1:0] instr_mem,
  input  logic            valid_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_mem,
  output logic [XLEN-1:0] pc_wb,
  output logic [XLEN-1:0] alu_wb,
  output logic [XLEN-1:0] load_wb,
  output logic [XLEN-1:0] instr_wb,
  output logic            valid_wb,
  output logic            exc_wb,
  output logic [1:0]      exc_cause_wb
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_LD_MIS  = 2'b01;
  localparam logic [1:0] CAUSE_ST_MIS  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] off;
  logic       is_load, is_store;
  logic       size_half, size_word;
  logic       misaligned;
  logic       mem_op;
  logic       req_raw;
  logic       timeout_now;
  logic       acked;

  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  logic [XLEN-1:0] load_d;
  logic            exc_d;
  logic [1:0]      cause_d;

  assign opcode = instr_mem[6:0];
  assign funct3 = instr_mem[14:12];
  assign off    = alu_mem[1:0];

  // Decode: only the listed funct3 encodings count as memory ops.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    if (opcode == OP_LOAD) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load = 1'b1;
        default:                                is_load = 1'b0;
      endcase
    end else if (opcode == OP_STORE) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: is_store = 1'b1;
        default:                is_store = 1'b0;
      endcase
    end
  end

  assign size_half  = (funct3[1:0] == 2'b01);
  assign size_word  = (funct3[1:0] == 2'b10);
  assign misaligned = (is_load | is_store) &
                      ((size_half & off[0]) | (size_word & (off != 2'b00)));
  assign mem_op     = valid_mem & (is_load | is_store) & ~misaligned;

  // Bus FSM state and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, raw request and timeout detection. The request is dropped in
  // the cycle the counter hits its last value, so an ack there is ignored.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_raw     = 1'b0;
    timeout_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          req_raw = 1'b1;
          if (!dmem_ack) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          timeout_now = 1'b1;
          state_d     = S_IDLE;
        end else begin
          req_raw = 1'b1;
          if (dmem_ack) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset gates the request combinationally so an in-flight access is killed at once.
  assign dmem_req  = req_raw & ~rst;
  assign stall_mem = dmem_req & ~dmem_ack & ~timeout_now;
  assign acked     = dmem_req & dmem_ack;

  assign dmem_we   = is_store;
  assign dmem_addr = {alu_mem[XLEN-1:2], 2'b00};

  // Byte enables and lane-replicated store data.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = rs2_mem;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << off;
          dmem_wdata = {(XLEN/8){rs2_mem[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << off;
          dmem_wdata = {(XLEN/16){rs2_mem[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = rs2_mem;
        end
      endcase
    end
  end

  assign byte_sel = dmem_rdata[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  // Lane select and sign/zero extension of the returned load word.
  always_comb begin
    case (funct3)
      3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  // Writeback entry contents for a completing cycle.
  always_comb begin
    load_d  = '0;
    exc_d   = 1'b0;
    cause_d = CAUSE_NONE;
    if (timeout_now) begin
      exc_d   = 1'b1;
      cause_d = CAUSE_TIMEOUT;
    end else if (valid_mem && misaligned) begin
      exc_d   = 1'b1;
      cause_d = is_load ? CAUSE_LD_MIS : CAUSE_ST_MIS;
    end else if (is_load && acked) begin
      load_d = load_data;
    end
  end

  // WB registers: bubble while stalled (payload held), capture otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_wb        <= '0;
      alu_wb       <= '0;
      load_wb      <= '0;
      instr_wb     <= '0;
      valid_wb     <= 1'b0;
      exc_wb       <= 1'b0;
      exc_cause_wb <= CAUSE_NONE;
    end else if (stall_mem) begin
      valid_wb     <= 1'b0;
      exc_wb       <= 1'b0;
      exc_cause_wb <= CAUSE_NONE;
    end else begin
      pc_wb        <= pc_mem;
      alu_wb       <= alu_mem;
      load_wb      <= load_d;
      instr_wb     <= instr_mem;
      valid_wb     <= valid_mem;
      exc_wb       <= exc_d;
      exc_cause_wb <= cause_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a queue-based writeback scoreboard.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_mem = '0, alu_mem = '0, rs2_mem = '0, instr_mem = '0;
  logic        valid_mem = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_mem;
  logic [31:0] pc_wb, alu_wb, load_wb, instr_wb;
  logic        valid_wb, exc_wb;
  logic [1:0]  exc_cause_wb;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] load;
    logic        exc;
    logic [1:0]  cause;
  } wb_t;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_err    = 0;

  mem_access #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .pc_mem(pc_mem), .alu_mem(alu_mem), .rs2_mem(rs2_mem), .instr_mem(instr_mem),
    .valid_mem(valid_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_mem(stall_mem),
    .pc_wb(pc_wb), .alu_wb(alu_wb), .load_wb(load_wb), .instr_wb(instr_wb),
    .valid_wb(valid_wb), .exc_wb(exc_wb), .exc_cause_wb(exc_cause_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] OP = 7'b0110011;

  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [31:0] instr, input logic ack, input logic [31:0] rdata);
    @(negedge clk);
    pc_mem     = pc;
    alu_mem    = alu;
    rs2_mem    = rs2;
    instr_mem  = instr;
    valid_mem  = 1'b1;
    dmem_ack   = ack;
    dmem_rdata = rdata;
  endtask

  task automatic expect_wb(input logic [31:0] pc, input logic [31:0] load,
                           input logic exc, input logic [1:0] cause);
    wb_t e;
    e.pc = pc; e.load = load; e.exc = exc; e.cause = cause;
    exp_q.push_back(e);
  endtask

  // Monitor: every valid writeback entry must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && valid_wb) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected_entry_pc", pc_wb, 32'hFFFF_FFFF);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_pc", pc_wb, e.pc);
        chk("wb_load", load_wb, e.load);
        chk("wb_exc", {31'd0, exc_wb}, {31'd0, e.exc});
        chk("wb_cause", {30'd0, exc_cause_wb}, {30'd0, e.cause});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a0, w0;
    logic [3:0]  b0;

    // Reset: registered outputs zero and request masked even with a valid LW present
    #1 rst = 1'b1;
    pc_mem = 32'h10; alu_mem = 32'h100; instr_mem = mk(LD, 3'b010); valid_mem = 1'b1;
    #11;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_pc_wb", pc_wb, 32'd0);
    chk("rst_valid_wb", {31'd0, valid_wb}, 32'd0);
    chk("rst_cause_wb", {30'd0, exc_cause_wb}, 32'd0);
    @(negedge clk); valid_mem = 1'b0;
    @(negedge clk); rst = 1'b0;

    // LW 0x100, same-cycle ack
    issue(32'h1000, 32'h100, 32'h0, mk(LD, 3'b010), 1'b1, 32'hDEADBEEF);
    #1;
    chk("lw_req", {31'd0, dmem_req}, 32'd1);
    chk("lw_stall", {31'd0, stall_mem}, 32'd0);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_be", {28'd0, dmem_be}, 32'hF);
    expect_wb(32'h1000, 32'hDEADBEEF, 1'b0, 2'b00);

    // LB / LBU at 0x103
    issue(32'h1004, 32'h103, 32'h0, mk(LD, 3'b000), 1'b1, 32'h80112233);
    #1 chk("lb_be", {28'd0, dmem_be}, 32'hF);
    expect_wb(32'h1004, 32'hFFFFFF80, 1'b0, 2'b00);
    issue(32'h1008, 32'h103, 32'h0, mk(LD, 3'b100), 1'b1, 32'h80112233);
    expect_wb(32'h1008, 32'h00000080, 1'b0, 2'b00);

    // LH / LHU at 0x102 (upper halfword)
    issue(32'h100C, 32'h102, 32'h0, mk(LD, 3'b001), 1'b1, 32'h80011234);
    expect_wb(32'h100C, 32'hFFFF8001, 1'b0, 2'b00);
    issue(32'h1010, 32'h102, 32'h0, mk(LD, 3'b101), 1'b1, 32'h80011234);
    expect_wb(32'h1010, 32'h00008001, 1'b0, 2'b00);

    // SH at 0x102
    issue(32'h1014, 32'h102, 32'h1234ABCD, mk(ST, 3'b001), 1'b1, 32'h0);
    #1;
    chk("sh_we", {31'd0, dmem_we}, 32'd1);
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_addr", dmem_addr, 32'h100);
    expect_wb(32'h1014, 32'h0, 1'b0, 2'b00);

    // SB at 0x201
    issue(32'h1018, 32'h201, 32'h00000055, mk(ST, 3'b000), 1'b1, 32'h0);
    #1;
    chk("sb_be", {28'd0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h55555555);
    chk("sb_addr", dmem_addr, 32'h200);
    expect_wb(32'h1018, 32'h0, 1'b0, 2'b00);

    // Misaligned LH and SW: no request, exception next edge
    issue(32'h101C, 32'h101, 32'h0, mk(LD, 3'b001), 1'b0, 32'h0);
    #1;
    chk("lh_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("lh_mis_stall", {31'd0, stall_mem}, 32'd0);
    expect_wb(32'h101C, 32'h0, 1'b1, 2'b01);
    issue(32'h1020, 32'h202, 32'h0, mk(ST, 3'b010), 1'b0, 32'h0);
    #1 chk("sw_mis_req", {31'd0, dmem_req}, 32'd0);
    expect_wb(32'h1020, 32'h0, 1'b1, 2'b10);

    // Pass-through ALU op, then an invalid slot (no entry expected)
    issue(32'h1024, 32'h5, 32'h0, mk(OP, 3'b000), 1'b0, 32'h0);
    #1 chk("op_req", {31'd0, dmem_req}, 32'd0);
    expect_wb(32'h1024, 32'h0, 1'b0, 2'b00);
    issue(32'h1028, 32'h100, 32'h0, mk(LD, 3'b010), 1'b0, 32'h0);
    valid_mem = 1'b0;
    #1 chk("inv_req", {31'd0, dmem_req}, 32'd0);

    // SW 0x200, ack delayed 3 cycles
    issue(32'h102C, 32'h200, 32'hCAFEF00D, mk(ST, 3'b010), 1'b0, 32'h0);
    expect_wb(32'h102C, 32'h0, 1'b0, 2'b00);
    #1;
    a0 = dmem_addr; b0 = dmem_be; w0 = dmem_wdata;
    chk("sw_addr", a0, 32'h200);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
        chk("sw_wait_valid_wb", {31'd0, valid_wb}, 32'd0);
        chk("sw_wait_stable", {dmem_addr[27:0], dmem_be}, {a0[27:0], b0});
        chk("sw_wait_wdata", dmem_wdata, w0);
      end
      if (stall_mem) n++;
    end
    chk("sw_stall_cycles", n, 32'd3);
    @(negedge clk); dmem_ack = 1'b1;
    #1;
    chk("sw_ack_req", {31'd0, dmem_req}, 32'd1);
    chk("sw_ack_stall", {31'd0, stall_mem}, 32'd0);

    // LW 0x300 with no ack: times out after 16 request cycles
    issue(32'h1030, 32'h300, 32'h0, mk(LD, 3'b010), 1'b0, 32'h12345678);
    expect_wb(32'h1030, 32'h0, 1'b1, 2'b11);
    #1;
    n = 0;
    while (dmem_req && n < 40) begin
      n++;
      @(negedge clk); #1;
    end
    chk("to_req_cycles", n, 32'd16);
    chk("to_stall", {31'd0, stall_mem}, 32'd0);

    // Reset pulsed in the middle of a wait
    issue(32'h1034, 32'h400, 32'h0, mk(LD, 3'b010), 1'b0, 32'h0);
    @(negedge clk); @(negedge clk);
    #1 chk("pre_rst_stall", {31'd0, stall_mem}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_req", {31'd0, dmem_req}, 32'd0);
    chk("midrst_stall", {31'd0, stall_mem}, 32'd0);
    chk("midrst_pc_wb", pc_wb, 32'd0);
    chk("midrst_alu_wb", alu_wb, 32'd0);
    chk("midrst_instr_wb", instr_wb, 32'd0);
    chk("midrst_flags", {29'd0, valid_wb, exc_wb, exc_cause_wb[0]}, 32'd0);
    @(negedge clk); valid_mem = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1 chk("post_rst_req", {31'd0, dmem_req}, 32'd0);

    issue(32'h1038, 32'h104, 32'h0, mk(LD, 3'b010), 1'b1, 32'h0BADF00D);
    #1 chk("fresh_lw_stall", {31'd0, stall_mem}, 32'd0);
    expect_wb(32'h1038, 32'h0BADF00D, 1'b0, 2'b00);

    @(negedge clk); valid_mem = 1'b0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
